vector_decode_stage: RTL and testbench
======================================

# vector_decode_stage

Parametrised decode stage for the vectorial CPU. It holds a multi-lane register file and reads two vector operands per instruction. Decode-side controls and operands are captured into a registered ID/EX pipeline register with valid, stall and flush control. It sits between the fetch/IF-ID register and the execute stage, and accepts per-lane write-back from the WB stage.

## Interface
Parameters:
- DATA_W, 32, lane element width
- LANES, 4, vector lanes per register
- NREGS, 32, architectural vector registers (power of two, ≥2)
- ADDR_W, 5, register address width (= log2 NREGS)
- PC_W, 48, program-counter width
- IMM_W, 32, immediate width

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-low
- in_valid  in  1  IF/ID slot holds a valid instruction
- stall  in  1  hold ID/EX register contents
- flush  in  1  squash instruction entering ID/EX
- pc1  in  PC_W  instruction PC
- opcode  in  6  opcode
- rs, rd  in  ADDR_W each  source / destination register addresses
- immediate  in  IMM_W  immediate
- flagsDECO  in  1  operand read enable
- flagsALU / flagsMEM / flagsWB  in  4 / 3 / 2  downstream control flags
- wb_en  in  1  write-back strobe
- wb_addr  in  ADDR_W  write-back register
- wb_mask  in  LANES  per-lane write enable
- wb_data  in  LANES*DATA_W  write-back data, lane 0 in LSBs
- out_valid  out  1  ID/EX slot valid
- pc_out, opcode_out, rd_out, immediate_out  out  as inputs  registered copies
- flagsALU_out / flagsMEM_out / flagsWB_out  out  4 / 3 / 2  registered flags
- dataOne, dataTwo  out  LANES*DATA_W  registered operands read from rs / rd

## Operation
- Register file: NREGS × LANES × DATA_W. Two combinational read ports (rs, rd) and one write port.
- Write: on a clk edge with wb_en=1 and wb_addr≠0, lane i is written iff wb_mask[i]=1.
- R0 always reads zero. Writes to R0 are ignored.
- Read enable: with flagsDECO=0, the captured dataOne/dataTwo are zero regardless of rs/rd.
- Priority each edge, highest first: rst=0, then flush, then stall, then normal capture.
- rst=0: every register-file entry and every output clears to 0, including out_valid.
- flush=1 (rst=1): out_valid←0 and all flag outputs ←0. Data fields may load but carry no meaning. flush overrides stall.
- stall=1 (no flush): all ID/EX outputs hold. The register-file write still occurs.
- Normal edge: out_valid←in_valid. All fields load from the current inputs and read data.
- in_valid=0 captures a bubble: out_valid=0 and flags zeroed.

## Timing
- Latency: one cycle from input presentation to registered outputs.
- Write-to-read: a write at edge N is visible to reads captured at edge N+1.
- Same-edge read of the register being written is governed by WB_BYPASS_EN (see Configuration).
- Stall held for K cycles: outputs stable for K cycles. Capture resumes on the first edge with stall=0.
- Reset asserted mid-stream: state clears on that edge. Writes presented in the same cycle are dropped.
- No combinational path from any input to any output.

## Configuration
- WB_BYPASS_EN defined:
  - When wb_en=1 and wb_addr equals rs (or rd), with address ≠0 and flagsDECO=1, each lane with wb_mask[i]=1 captures wb_data lane i.
  - Unmasked lanes capture stored data.
  - This makes write-then-read back-to-back hazard-free.
- WB_BYPASS_EN undefined:
  - Reads capture the pre-write stored value.
  - Software or the hazard unit must leave one idle cycle between a write-back and a dependent decode.

## Test plan
- Reset: rst=0 for 2 cycles with random inputs → all outputs 0. Reading R1..R31 afterwards returns 0.
- Write/read: write R5 = {4,3,2,1} with mask 4'b1111. Next cycle decode rs=5, rd=0, flagsDECO=1 → dataOne={4,3,2,1}, dataTwo=0, out_valid=1 one cycle later.
- Lane mask: R7={8,8,8,8}, then write R7={1,1,1,1} with mask 4'b0101 → read gives {8,1,8,1}. A write to R0 then reads 0.
- Same-cycle hazard: write R3={9,9,9,9} while decoding rs=3. With WB_BYPASS_EN → dataOne={9,9,9,9}. Without it → the old R3 value.
- Stall/flush: stall=1 for 3 cycles → outputs frozen. Then stall=1 together with flush=1 → out_valid=0 and flagsALU_out=0 on that edge.
- flagsDECO=0 with rs=5 (R5 nonzero) → dataOne=0. Flags and immediate (0xDEADBEEF) pass through registered.

Source files
------------

// File: rtl/vector_decode_stage.sv
// vector_decode_stage
//    Decode stage of the vector CPU: a NREGS x LANES x DATA_W register file
//    with two combinational read ports (rs, rd) and one lane-masked write
//    port, feeding a registered ID/EX pipeline register with valid, stall
//    and flush control.
//
// Optional feature macro: WB_BYPASS_EN
//    defined   - a write-back to the register being decoded on the same edge
//                forwards wb_data into the captured operand (masked lanes only)
//    undefined - operands capture the pre-write stored value
//
// Ports
//    clk, rst                 clock, synchronous active-low reset
//    in_valid, stall, flush   ID/EX slot control
//    pc1, opcode, rs, rd,     decode-side fields from IF/ID
//    immediate, flagsDECO,
//    flagsALU/MEM/WB
//    wb_en, wb_addr,          per-lane write-back from WB
//    wb_mask, wb_data
//    out_valid, pc_out, opcode_out, rd_out, immediate_out,
//    flagsALU_out/MEM_out/WB_out, dataOne, dataTwo   registered ID/EX outputs
module vector_decode_stage #(
   parameter int DATA_W = 32,
   parameter int LANES  = 4,
   parameter int NREGS  = 32,
   parameter int ADDR_W = 5,
   parameter int PC_W   = 48,
   parameter int IMM_W  = 32
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_valid,
   input  logic                      stall,
   input  logic                      flush,
   input  logic [PC_W-1:0]           pc1,
   input  logic [5:0]                opcode,
   input  logic [ADDR_W-1:0]         rs,
   input  logic [ADDR_W-1:0]         rd,
   input  logic [IMM_W-1:0]          immediate,
   input  logic                      flagsDECO,
   input  logic [3:0]                flagsALU,
   input  logic [2:0]                flagsMEM,
   input  logic [1:0]                flagsWB,
   input  logic                      wb_en,
   input  logic [ADDR_W-1:0]         wb_addr,
   input  logic [LANES-1:0]          wb_mask,
   input  logic [LANES*DATA_W-1:0]   wb_data,
   output logic                      out_valid,
   output logic [PC_W-1:0]           pc_out,
   output logic [5:0]                opcode_out,
   output logic [ADDR_W-1:0]         rd_out,
   output logic [IMM_W-1:0]          immediate_out,
   output logic [3:0]                flagsALU_out,
   output logic [2:0]                flagsMEM_out,
   output logic [1:0]                flagsWB_out,
   output logic [LANES*DATA_W-1:0]   dataOne,
   output logic [LANES*DATA_W-1:0]   dataTwo
);

   logic [DATA_W-1:0]       r_rf [NREGS][LANES];
   logic [LANES*DATA_W-1:0] w_data_one;
   logic [LANES*DATA_W-1:0] w_data_two;
   logic                    w_wb_write;

   assign w_wb_write = wb_en && (wb_addr != '0);

   // Register file: the whole array clears on reset, so writes presented
   // in a reset cycle are dropped. R0 is never written.
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int r = 0; r < NREGS; r++) begin
            for (int l = 0; l < LANES; l++) begin
               r_rf[r][l] <= '0;
            end
         end
      end else if (w_wb_write) begin
         for (int l = 0; l < LANES; l++) begin
            if (wb_mask[l]) begin
               r_rf[wb_addr][l] <= wb_data[l*DATA_W +: DATA_W];
            end
         end
      end
   end

   // Operand read. R0 and a disabled read both force zero; the optional
   // bypass replaces only the lanes being written this edge.
   always_comb begin
      w_data_one = '0;
      w_data_two = '0;
      for (int l = 0; l < LANES; l++) begin
         w_data_one[l*DATA_W +: DATA_W] = r_rf[rs][l];
         w_data_two[l*DATA_W +: DATA_W] = r_rf[rd][l];
`ifdef WB_BYPASS_EN
         if (w_wb_write && (wb_addr == rs) && wb_mask[l]) begin
            w_data_one[l*DATA_W +: DATA_W] = wb_data[l*DATA_W +: DATA_W];
         end
         if (w_wb_write && (wb_addr == rd) && wb_mask[l]) begin
            w_data_two[l*DATA_W +: DATA_W] = wb_data[l*DATA_W +: DATA_W];
         end
`endif
      end
      if (rs == '0 || !flagsDECO) begin
         w_data_one = '0;
      end
      if (rd == '0 || !flagsDECO) begin
         w_data_two = '0;
      end
   end

   // ID/EX register. Flush beats stall; on flush the data fields still load
   // (they are meaningless with out_valid low) to keep the enable logic simple.
   always_ff @(posedge clk) begin
      if (!rst) begin
         out_valid     <= 1'b0;
         pc_out        <= '0;
         opcode_out    <= '0;
         rd_out        <= '0;
         immediate_out <= '0;
         flagsALU_out  <= '0;
         flagsMEM_out  <= '0;
         flagsWB_out   <= '0;
         dataOne       <= '0;
         dataTwo       <= '0;
      end else if (flush || !stall) begin
         pc_out        <= pc1;
         opcode_out    <= opcode;
         rd_out        <= rd;
         immediate_out <= immediate;
         dataOne       <= w_data_one;
         dataTwo       <= w_data_two;
         if (flush || !in_valid) begin
            out_valid    <= 1'b0;
            flagsALU_out <= '0;
            flagsMEM_out <= '0;
            flagsWB_out  <= '0;
         end else begin
            out_valid    <= 1'b1;
            flagsALU_out <= flagsALU;
            flagsMEM_out <= flagsMEM;
            flagsWB_out  <= flagsWB;
         end
      end
   end

endmodule

// File: tb/tb_vector_decode_stage.sv
module tb_vector_decode_stage;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid, stall, flush;
   logic [47:0]   pc1;
   logic [5:0]    opcode;
   logic [4:0]    rs, rd;
   logic [31:0]   immediate;
   logic          flagsDECO;
   logic [3:0]    flagsALU;
   logic [2:0]    flagsMEM;
   logic [1:0]    flagsWB;
   logic          wb_en;
   logic [4:0]    wb_addr;
   logic [3:0]    wb_mask;
   logic [127:0]  wb_data;
   logic          out_valid;
   logic [47:0]   pc_out;
   logic [5:0]    opcode_out;
   logic [4:0]    rd_out;
   logic [31:0]   immediate_out;
   logic [3:0]    flagsALU_out;
   logic [2:0]    flagsMEM_out;
   logic [1:0]    flagsWB_out;
   logic [127:0]  dataOne, dataTwo;

   int n_vec = 0;
   int n_err = 0;

   vector_decode_stage dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .stall(stall), .flush(flush),
      .pc1(pc1), .opcode(opcode), .rs(rs), .rd(rd), .immediate(immediate),
      .flagsDECO(flagsDECO), .flagsALU(flagsALU), .flagsMEM(flagsMEM),
      .flagsWB(flagsWB), .wb_en(wb_en), .wb_addr(wb_addr), .wb_mask(wb_mask),
      .wb_data(wb_data), .out_valid(out_valid), .pc_out(pc_out),
      .opcode_out(opcode_out), .rd_out(rd_out), .immediate_out(immediate_out),
      .flagsALU_out(flagsALU_out), .flagsMEM_out(flagsMEM_out),
      .flagsWB_out(flagsWB_out), .dataOne(dataOne), .dataTwo(dataTwo)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [127:0] v4(input logic [31:0] l3, l2, l1, l0);
      return {l3, l2, l1, l0};
   endfunction

   initial begin
      logic [127:0] old_r3;

      // reset with random inputs, including write-back attempts
      rst = 1'b0;
      for (int c = 0; c < 2; c++) begin
         in_valid = 1'b1; stall = 1'($urandom); flush = 1'($urandom);
         pc1 = 48'({$urandom(), $urandom()}); opcode = 6'($urandom);
         rs = 5'($urandom); rd = 5'($urandom); immediate = $urandom;
         flagsDECO = 1'b1; flagsALU = 4'($urandom); flagsMEM = 3'($urandom);
         flagsWB = 2'($urandom); wb_en = 1'b1; wb_addr = 5'd1 + 5'(c);
         wb_mask = 4'hF; wb_data = {$urandom, $urandom, $urandom, $urandom};
         tick;
      end
      chk("rst_valid", 128'(out_valid), 128'd0);
      chk("rst_pc", 128'(pc_out), 128'd0);
      chk("rst_imm", 128'(immediate_out), 128'd0);
      chk("rst_flags", 128'({flagsALU_out, flagsMEM_out, flagsWB_out}), 128'd0);
      chk("rst_ops", dataOne | dataTwo, 128'd0);

      rst = 1'b1; stall = 1'b0; flush = 1'b0; wb_en = 1'b0; flagsDECO = 1'b1;
      for (int r = 1; r < 32; r++) begin
         rs = 5'(r); rd = 5'(32 - r);
         tick;
         chk($sformatf("rst_rf_r%0d", r), dataOne | dataTwo, 128'd0);
      end

      // write R5 then decode it next cycle
      in_valid = 1'b0; wb_en = 1'b1; wb_addr = 5'd5; wb_mask = 4'hF;
      wb_data = v4(4, 3, 2, 1);
      tick;
      wb_en = 1'b0; in_valid = 1'b1; rs = 5'd5; rd = 5'd0; opcode = 6'h2A;
      pc1 = 48'h1234_5678_9ABC; flagsALU = 4'h3; flagsMEM = 3'h5; flagsWB = 2'h1;
      tick;
      chk("r5_one", dataOne, v4(4, 3, 2, 1));
      chk("r5_two", dataTwo, 128'd0);
      chk("r5_valid", 128'(out_valid), 128'd1);
      chk("r5_opcode", 128'(opcode_out), 128'h2A);
      chk("r5_pc", 128'(pc_out), 128'h1234_5678_9ABC);
      chk("r5_rd_out", 128'(rd_out), 128'd0);

      // lane mask
      wb_en = 1'b1; wb_addr = 5'd7; wb_mask = 4'hF; wb_data = v4(8, 8, 8, 8);
      tick;
      wb_mask = 4'b0101; wb_data = v4(1, 1, 1, 1);
      tick;
      wb_en = 1'b0; rs = 5'd7; rd = 5'd7;
      tick;
      chk("mask_one", dataOne, v4(8, 1, 8, 1));
      chk("mask_two", dataTwo, v4(8, 1, 8, 1));
      chk("mask_rd_out", 128'(rd_out), 128'd7);

      // write to R0 is ignored
      wb_en = 1'b1; wb_addr = 5'd0; wb_mask = 4'hF; wb_data = v4(7, 7, 7, 7);
      tick;
      wb_en = 1'b0; rs = 5'd0; rd = 5'd0;
      tick;
      chk("r0_one", dataOne, 128'd0);
      chk("r0_two", dataTwo, 128'd0);

      // same-edge hazard on R3
      old_r3 = v4(2, 2, 2, 2);
      wb_en = 1'b1; wb_addr = 5'd3; wb_mask = 4'hF; wb_data = old_r3;
      tick;
      wb_data = v4(9, 9, 9, 9); rs = 5'd3; rd = 5'd3;
      tick;
`ifdef WB_BYPASS_EN
      chk("hazard_one", dataOne, v4(9, 9, 9, 9));
`else
      chk("hazard_one", dataOne, old_r3);
`endif
      wb_en = 1'b0;
      tick;
      chk("hazard_next", dataOne, v4(9, 9, 9, 9));

      // stall: capture a known instruction, then freeze for 3 cycles
      in_valid = 1'b1; pc1 = 48'hAAAA_0000_0001; opcode = 6'h11; rs = 5'd5;
      rd = 5'd7; immediate = 32'h0000_1111; flagsALU = 4'hA; flagsMEM = 3'h6;
      flagsWB = 2'h2;
      tick;
      chk("pre_stall_alu", 128'(flagsALU_out), 128'hA);
      stall = 1'b1; pc1 = 48'hBBBB_0000_0002; opcode = 6'h22; rs = 5'd3;
      immediate = 32'h2222_2222; flagsALU = 4'h5; in_valid = 1'b0;
      wb_en = 1'b1; wb_addr = 5'd9; wb_mask = 4'hF; wb_data = v4(6, 5, 4, 3);
      for (int k = 0; k < 3; k++) begin
         tick;
         chk($sformatf("stall%0d_valid", k), 128'(out_valid), 128'd1);
         chk($sformatf("stall%0d_pc", k), 128'(pc_out), 128'hAAAA_0000_0001);
         chk($sformatf("stall%0d_alu", k), 128'(flagsALU_out), 128'hA);
         chk($sformatf("stall%0d_one", k), dataOne, v4(4, 3, 2, 1));
         wb_en = 1'b0;
      end
      flush = 1'b1; in_valid = 1'b1;
      tick;
      chk("flush_valid", 128'(out_valid), 128'd0);
      chk("flush_flags", 128'({flagsALU_out, flagsMEM_out, flagsWB_out}), 128'd0);

      // write during stall landed; bubble zeroes flags
      flush = 1'b0; stall = 1'b0; in_valid = 1'b0; rs = 5'd9; flagsALU = 4'hF;
      flagsMEM = 3'h7; flagsWB = 2'h3;
      tick;
      chk("stall_write", dataOne, v4(6, 5, 4, 3));
      chk("bubble_valid", 128'(out_valid), 128'd0);
      chk("bubble_flags", 128'({flagsALU_out, flagsMEM_out, flagsWB_out}), 128'd0);

      // read disabled
      in_valid = 1'b1; flagsDECO = 1'b0; rs = 5'd5; rd = 5'd5;
      immediate = 32'hDEAD_BEEF; flagsALU = 4'h9; flagsMEM = 3'h4; flagsWB = 2'h1;
      tick;
      chk("deco0_one", dataOne, 128'd0);
      chk("deco0_two", dataTwo, 128'd0);
      chk("deco0_imm", 128'(immediate_out), 128'hDEAD_BEEF);
      chk("deco0_flags", 128'({flagsALU_out, flagsMEM_out, flagsWB_out}),
          128'({4'h9, 3'h4, 2'h1}));

      // mid-stream reset drops the simultaneous write and clears the file
      flagsDECO = 1'b1; rst = 1'b0; wb_en = 1'b1; wb_addr = 5'd5;
      wb_data = v4(1, 1, 1, 1);
      tick;
      chk("mrst_valid", 128'(out_valid), 128'd0);
      chk("mrst_one", dataOne, 128'd0);
      rst = 1'b1; wb_en = 1'b0; rs = 5'd5; rd = 5'd9;
      tick;
      chk("mrst_r5", dataOne, 128'd0);
      chk("mrst_r9", dataTwo, 128'd0);
      chk("mrst_valid_after", 128'(out_valid), 128'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
